// File: rtl/unsigned_div_pkg.sv
// unsigned_div_pkg: state encoding and default data width shared by the execute-stage arithmetic units
package unsigned_div_pkg;

    localparam int DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/unsigned_div_if.sv
// unsigned_div_if: start/busy/done handshake and operand/result bus of the divider
interface unsigned_div_if
    import unsigned_div_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) ();

    logic             start;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] rem;
    logic             dz;

    modport master (
        output start, x, y,
        input  busy, done, quot, rem, dz
    );

    modport slave (
        input  start, x, y,
        output busy, done, quot, rem, dz
    );

endinterface

// File: rtl/unsigned_div_step.sv
// div_step: one combinational restoring-division iteration producing the next remainder and quotient
module div_step
    import unsigned_div_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic [WIDTH:0]   r,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH:0]   r_nxt,
    output logic [WIDTH-1:0] q_nxt
);

    logic [WIDTH:0] sh;
    logic           ge;

    // the compare sees the full remainder so a stray top bit can never hide an overflow
    assign sh    = {r[WIDTH-1:0], q[WIDTH-1]};
    assign ge    = {r, q[WIDTH-1]} >= {2'b00, d};
    assign r_nxt = ge ? sh - {1'b0, d} : sh;
    assign q_nxt = {q[WIDTH-2:0], ge};

endmodule

// File: rtl/unsigned_div.sv
// unsigned_div: sequential restoring divider, one quotient bit per cycle, start/busy/done handshake
module unsigned_div
    import unsigned_div_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input logic          clk,
    input logic          rst,
    unsigned_div_if.slave bus
);

    localparam int CW = $clog2(WIDTH);

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   r;
    logic [WIDTH:0]   r_nxt;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_nxt;
    logic [WIDTH-1:0] d;
    logic             last;
    logic             accept;
    logic             zero;

    div_step #(.WIDTH(WIDTH)) u_step (
        .r    (r),
        .q    (q),
        .d    (d),
        .r_nxt(r_nxt),
        .q_nxt(q_nxt)
    );

    assign last     = cnt == CW'(WIDTH - 1);
    assign accept   = state != RUN && bus.start;
    assign zero     = bus.y == '0;
    assign bus.busy = state == RUN;
    assign bus.done = state == DONE;

    always_comb begin
        state_nxt = state;
        if (state == RUN)
            state_nxt = last ? DONE : RUN;
        else
            state_nxt = !bus.start ? IDLE : zero ? DONE : RUN;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            r        <= '0;
            q        <= '0;
            d        <= '0;
            bus.quot <= '0;
            bus.rem  <= '0;
            bus.dz   <= 1'b0;
        end else if (accept) begin
            cnt    <= '0;
            r      <= '0;
            q      <= bus.x;
            d      <= bus.y;
            bus.dz <= zero;
            // divide by zero skips the iterations and publishes its result immediately
            if (zero) begin
                bus.quot <= '1;
                bus.rem  <= bus.x;
            end
        end else if (state == RUN) begin
            cnt <= cnt + CW'(1);
            r   <= r_nxt;
            q   <= q_nxt;
            if (last) begin
                bus.quot <= q_nxt;
                bus.rem  <= r_nxt[WIDTH-1:0];
            end
        end
    end

endmodule

// File: tb/tb_unsigned_div.sv
// tb_unsigned_div: directed and randomized checks of the sequential unsigned divider
module tb_unsigned_div;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    unsigned_div_if #(.WIDTH(W)) bus ();

    unsigned_div #(.WIDTH(W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
        bus.start = 1'b1;
        bus.x     = a;
        bus.y     = b;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int n, output logic busy_ok);
        n       = 1;
        busy_ok = 1'b1;
        while (!bus.done && n < 100) begin
            busy_ok &= bus.busy;
            tick();
            n++;
        end
    endtask

    task automatic op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz, input int elat);
        int   n;
        logic busy_ok;
        launch(a, b);
        wait_done(n, busy_ok);
        check({tag, "_lat"}, 64'(n), 64'(elat));
        check({tag, "_busy_run"}, 64'(busy_ok), 64'd1);
        check({tag, "_busy_done"}, 64'(bus.busy), 64'd0);
        check({tag, "_quot"}, 64'(bus.quot), 64'(eq));
        check({tag, "_rem"}, 64'(bus.rem), 64'(er));
        check({tag, "_dz"}, 64'(bus.dz), 64'(edz));
        tick();
        check({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
    endtask

    initial begin
        int          n;
        logic        busy_ok;
        logic        seen;
        logic        stable;
        logic [W-1:0] a;
        logic [W-1:0] b;
        bus.start = 1'b0;
        bus.x     = '0;
        bus.y     = '0;
        tick();
        tick();
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_quot", 64'(bus.quot), 64'd0);
        check("rst_rem", 64'(bus.rem), 64'd0);
        check("rst_dz", 64'(bus.dz), 64'd0);
        rst = 1'b0;
        tick();

        op("d100_7", 100, 7, 14, 2, 1'b0, 33);
        op("dmax_1", 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 0, 1'b0, 33);
        op("dmax_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0, 1'b0, 33);
        op("d3_10", 3, 10, 0, 3, 1'b0, 33);
        op("d0_5", 0, 5, 0, 0, 1'b0, 33);
        op("d5_0", 5, 0, 32'hFFFF_FFFF, 5, 1'b1, 1);
        op("d1_3", 1, 3, 0, 1, 1'b0, 33);
        op("dmsb_2", 32'h8000_0001, 2, 32'h4000_0000, 1, 1'b0, 33);

        launch(100, 7);
        n       = 1;
        busy_ok = 1'b1;
        while (!bus.done && n < 100) begin
            bus.start = n == 10;
            bus.x     = 9;
            bus.y     = 3;
            busy_ok  &= bus.busy;
            tick();
            n++;
        end
        bus.start = 1'b0;
        check("ign_lat", 64'(n), 64'd33);
        check("ign_busy", 64'(busy_ok), 64'd1);
        check("ign_quot", 64'(bus.quot), 64'd14);
        check("ign_rem", 64'(bus.rem), 64'd2);
        tick();

        launch(100, 7);
        repeat (19) tick();
        check("pre_rst_busy", 64'(bus.busy), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_busy", 64'(bus.busy), 64'd0);
        check("mid_rst_done", 64'(bus.done), 64'd0);
        check("mid_rst_quot", 64'(bus.quot), 64'd0);
        check("mid_rst_rem", 64'(bus.rem), 64'd0);
        check("mid_rst_dz", 64'(bus.dz), 64'd0);
        seen = 1'b0;
        repeat (40) begin
            seen |= bus.done | bus.busy;
            tick();
        end
        check("mid_rst_quiet", 64'(seen), 64'd0);
        op("d9_3", 9, 3, 3, 0, 1'b0, 33);

        launch(100, 7);
        wait_done(n, busy_ok);
        check("b2b_lat1", 64'(n), 64'd33);
        check("b2b_quot1", 64'(bus.quot), 64'd14);
        bus.start = 1'b1;
        bus.x     = 50;
        bus.y     = 6;
        tick();
        bus.start = 1'b0;
        n      = 1;
        stable = 1'b1;
        while (!bus.done && n < 100) begin
            stable &= bus.quot == 14 && bus.rem == 2 && bus.busy;
            tick();
            n++;
        end
        check("b2b_stable", 64'(stable), 64'd1);
        check("b2b_lat2", 64'(n), 64'd33);
        check("b2b_quot2", 64'(bus.quot), 64'd8);
        check("b2b_rem2", 64'(bus.rem), 64'd2);
        tick();

        repeat (200) begin
            a = $urandom;
            b = $urandom;
            if ($urandom_range(1) == 1) b = b >> $urandom_range(31);
            if (b == 0) b = 1;
            op("rand", a, b, a / b, a % b, 1'b0, 33);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
